single_port_lut_ram: RTL and testbench

Synchronous single-port LUT-based RAM with per-byte write mask and registered read output. One address port serves both read and write. Used as the basic storage primitive under caches, tag arrays and small buffers.

---
 rtl/single_port_lut_ram_pkg.sv | 20 ++
 rtl/single_port_lut_ram_byte_mask_merge.sv | 31 +++
 rtl/single_port_lut_ram.sv | 104 ++++++++++
 tb/tb_single_port_lut_ram.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/single_port_lut_ram_pkg.sv
// -----------------------------------------------------------------------------
// single_port_lut_ram_pkg
// Shared constants for the single-port LUT RAM and its helpers.
//   BYTE_LEN_IN_BITS  : granularity of the per-byte write mask
//   FULL_CYCLE_DELAY  : simulation clock period (time units)
//   HALF_CYCLE_DELAY  : simulation clock half period (time units)
// -----------------------------------------------------------------------------
package single_port_lut_ram_pkg;

    localparam int BYTE_LEN_IN_BITS = 8;

    localparam int FULL_CYCLE_DELAY = 10;
    localparam int HALF_CYCLE_DELAY = FULL_CYCLE_DELAY / 2;

    // Number of byte lanes in an entry of the given width.
    function automatic int byte_lanes(input int entry_width);
        return entry_width / BYTE_LEN_IN_BITS;
    endfunction

endpackage

// File: rtl/single_port_lut_ram_byte_mask_merge.sv
// -----------------------------------------------------------------------------
// single_port_lut_ram_byte_mask_merge
// Purely combinational byte-lane merge: every lane whose mask bit is set takes
// the new entry's byte, every other lane keeps the old entry's byte.
// Ports:
//   old_entry    in  ENTRY_WIDTH     current contents of the addressed entry
//   new_entry    in  ENTRY_WIDTH     incoming write data
//   byte_mask    in  MASK_WIDTH      per-byte select, bit i covers [8i+7:8i]
//   merged_entry out ENTRY_WIDTH     lane-wise merge of old and new
// -----------------------------------------------------------------------------
module single_port_lut_ram_byte_mask_merge
    import single_port_lut_ram_pkg::*;
#(
    parameter int ENTRY_WIDTH = 64,
    localparam int MASK_WIDTH = ENTRY_WIDTH / BYTE_LEN_IN_BITS
) (
    input  logic [ENTRY_WIDTH-1:0] old_entry,
    input  logic [ENTRY_WIDTH-1:0] new_entry,
    input  logic [MASK_WIDTH-1:0]  byte_mask,
    output logic [ENTRY_WIDTH-1:0] merged_entry
);

    generate
        for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
            assign merged_entry[gi*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] =
                byte_mask[gi] ? new_entry[gi*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS]
                              : old_entry[gi*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
        end
    endgenerate

endmodule

// File: rtl/single_port_lut_ram.sv
// -----------------------------------------------------------------------------
// single_port_lut_ram
// Single-port distributed (LUT) RAM with per-byte write mask and a registered,
// write-first read port. One access per cycle, no handshake.
// Ports:
//   clk_in             in  1                          rising-edge clock
//   reset_in           in  1                          async active-low reset
//   access_en_in       in  1                          port enable
//   write_en_in        in  WRITE_MASK_LEN             per-byte write enable
//   access_set_addr_in in  SET_PTR_WIDTH_IN_BITS      entry index
//   write_entry_in     in  SINGLE_ENTRY_SIZE_IN_BITS  write data
//   read_entry_out     out SINGLE_ENTRY_SIZE_IN_BITS  registered read data
// Build option:
//   LUTRAM_RESET_CLEAR_EN  when defined, reset also clears every entry to 0.
//                          Left undefined, the array has no reset and maps
//                          onto plain LUTRAM.
// -----------------------------------------------------------------------------
module single_port_lut_ram
    import single_port_lut_ram_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    localparam int WRITE_MASK_LEN           = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out
);

    // One extra bit so the comparison also works when NUM_SET is a power of two.
    localparam logic [SET_PTR_WIDTH_IN_BITS:0] NUM_SET_EXT =
        (SET_PTR_WIDTH_IN_BITS + 1)'(NUM_SET);

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];

    logic                                 addr_in_range;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     safe_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] old_entry;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] merged_entry;
    logic                                 mem_write;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_reg;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_next;

    // Out-of-range addresses only exist when NUM_SET is not a power of two;
    // they are steered to entry 0 for the combinational lookup and their
    // result is discarded below.
    assign addr_in_range = ({1'b0, access_set_addr_in} < NUM_SET_EXT);
    assign safe_addr     = addr_in_range ? access_set_addr_in : '0;
    assign old_entry     = mem[safe_addr];

    single_port_lut_ram_byte_mask_merge #(
        .ENTRY_WIDTH (SINGLE_ENTRY_SIZE_IN_BITS)
    ) u_merge (
        .old_entry    (old_entry),
        .new_entry    (write_entry_in),
        .byte_mask    (write_en_in),
        .merged_entry (merged_entry)
    );

    assign mem_write = access_en_in && addr_in_range && (|write_en_in);

`ifdef LUTRAM_RESET_CLEAR_EN
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_SET; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write) begin
            mem[safe_addr] <= merged_entry;
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (mem_write) begin
            mem[safe_addr] <= merged_entry;
        end
    end
`endif

    // Write-first: the output takes the merged value, which equals the stored
    // entry when no byte is enabled (pure read).
    always_comb begin
        read_entry_next = read_entry_reg;
        if (access_en_in) begin
            read_entry_next = addr_in_range ? merged_entry : '0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            read_entry_reg <= '0;
        end else begin
            read_entry_reg <= read_entry_next;
        end
    end

    assign read_entry_out = read_entry_reg;

endmodule

// File: tb/tb_single_port_lut_ram.sv
// -----------------------------------------------------------------------------
// tb_single_port_lut_ram
// Drives two instances with identical stimulus: a 64-entry RAM and a 40-entry
// RAM whose upper addresses are out of range. A reference model predicts each
// cycle's output; a monitor compares them one cycle after issue.
// -----------------------------------------------------------------------------
module tb_single_port_lut_ram;
    import single_port_lut_ram_pkg::*;

    localparam int W    = 64;
    localparam int MW   = W / BYTE_LEN_IN_BITS;
    localparam int NS_A = 64;
    localparam int NS_B = 40;
    localparam int AW   = 6;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          access_en;
    logic [MW-1:0] write_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata_a;
    logic [W-1:0]  rdata_b;

    single_port_lut_ram #(
        .SINGLE_ENTRY_SIZE_IN_BITS (W),
        .NUM_SET                   (NS_A)
    ) dut_a (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .access_en_in       (access_en),
        .write_en_in        (write_en),
        .access_set_addr_in (addr),
        .write_entry_in     (wdata),
        .read_entry_out     (rdata_a)
    );

    single_port_lut_ram #(
        .SINGLE_ENTRY_SIZE_IN_BITS (W),
        .NUM_SET                   (NS_B)
    ) dut_b (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .access_en_in       (access_en),
        .write_en_in        (write_en),
        .access_set_addr_in (addr),
        .write_entry_in     (wdata),
        .read_entry_out     (rdata_b)
    );

    initial forever #HALF_CYCLE_DELAY clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
        int           due;
        int           tag;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] ref_a [NS_A];
    logic [W-1:0] ref_b [NS_B];
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    int           cycle  = 0;
    int           checks = 0;
    int           passes = 0;
    int           txn    = 0;

    always @(posedge clk_in) cycle <= cycle + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-mask merge as arithmetic on a bit-level mask.
    function automatic logic [W-1:0] merge_ref(input logic [W-1:0] old_v,
                                               input logic [W-1:0] new_v,
                                               input logic [MW-1:0] m);
        logic [W-1:0] bm;
        bm = '0;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) bm = bm | (64'hFF << (8 * b));
        end
        return (old_v & ~bm) | (new_v & bm);
    endfunction

    task automatic issue(input logic en, input logic [MW-1:0] m, input int a, input logic [W-1:0] d);
        @(negedge clk_in);
        access_en = en;
        write_en  = m;
        addr      = AW'(a);
        wdata     = d;
        if (en) begin
            if (a < NS_A) begin
                ref_a[a] = merge_ref(ref_a[a], d, m);
                out_a    = ref_a[a];
            end else begin
                out_a = '0;
            end
            if (a < NS_B) begin
                ref_b[a] = merge_ref(ref_b[a], d, m);
                out_b    = ref_b[a];
            end else begin
                out_b = '0;
            end
        end
        sb.push_back('{out_a, out_b, cycle + 1, txn});
        $display("txn %0d: en=%0b we=%h addr=%0d data=%h -> exp_a=%h exp_b=%h",
                 txn, en, m, a, d, out_a, out_b);
        txn++;
    endtask

    // Monitor: output of each issued access is due one clock after issue.
    always @(negedge clk_in) begin
        while (sb.size() != 0 && sb[0].due <= cycle) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("rd_a[%0d]", e.tag), rdata_a, e.exp_a);
            check($sformatf("rd_b[%0d]", e.tag), rdata_b, e.exp_b);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic mid_reset();
        drain();
        @(posedge clk_in);
        #2;
        reset_in  = 1'b0;
        access_en = 1'b0;
        out_a = '0;
        out_b = '0;
`ifdef LUTRAM_RESET_CLEAR_EN
        for (int i = 0; i < NS_A; i++) ref_a[i] = '0;
        for (int i = 0; i < NS_B; i++) ref_b[i] = '0;
`endif
        #1;
        check("async_rst_a", rdata_a, '0);
        check("async_rst_b", rdata_b, '0);
        @(posedge clk_in);
        #1;
        check("held_rst_a", rdata_a, '0);
        @(negedge clk_in);
        reset_in = 1'b1;
        $display("reset pulse applied at t=%0t", $time);
    endtask

    initial begin
        reset_in  = 1'b0;
        access_en = 1'b0;
        write_en  = '0;
        addr      = '0;
        wdata     = '0;
        out_a     = '0;
        out_b     = '0;
        #1;
        check("reset_a", rdata_a, '0);
        check("reset_b", rdata_b, '0);
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;

        // Directed scenarios
        issue(1'b1, 8'hFF, 63, 64'hFFFFFFFF00000000);
        issue(1'b1, 8'h00, 63, 64'h00000000FFFFFFFF);
        issue(1'b1, 8'hFF, 62, 64'h0);
        issue(1'b1, 8'hCC, 62, 64'hFFFFFFFFFFFFFFFF);
        issue(1'b0, 8'hFF, 63, 64'h1234);
        issue(1'b1, 8'h00, 63, 64'h0);
        issue(1'b1, 8'h00, 62, 64'h0);
        issue(1'b1, 8'h00, 63, 64'h0);
        drain();
        check("plan_addr63", ref_a[63], 64'hFFFFFFFF00000000);
        check("plan_addr62", ref_a[62], 64'hFFFF0000FFFF0000);

        mid_reset();
        issue(1'b1, 8'h00, 63, 64'h0);

        // Fill every address so random reads never touch uninitialised entries
        for (int a = 0; a < 64; a++) begin
            issue(1'b1, 8'hFF, a, {$urandom(), $urandom()});
        end

        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            issue($urandom_range(0, 9) != 0, MW'($urandom()), $urandom_range(0, 63),
                  {$urandom(), $urandom()});
        end

        issue(1'b0, 8'h00, 0, 64'h0);
        drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
